// File: rtl/clock_domain_importer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_domain_importer_pkg
// Description : Shared types and defaults for the toggle-handshake crossing.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_domain_importer_pkg;

    localparam int pClockDomainBits       = 8;
    localparam int pClockDomainSyncStages = 2;

    // Source-domain bundle: data is held stable from the req toggle until ack returns.
    typedef struct packed {
        logic [pClockDomainBits-1:0] data;
        logic                        req;
    } iClockDomain_Exp;

    typedef struct packed {
        logic ack;
    } iClockDomain_Imp;

endpackage
`default_nettype wire

// File: rtl/clock_domain_importer_sync.sv
`default_nettype none
// ============================================================================
// Module      : clock_domain_sync
// Description : N-stage single-bit synchronizer with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_domain_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < 2) begin : g_stage_check
        $error("clock_domain_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clock_domain_importer.sv
`default_nettype none
// ============================================================================
// Module      : clock_domain_importer
// Description : Destination side of the toggle-handshake crossing; captures the
//               bundled word, toggles ack, presents it on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_domain_importer
    import clock_domain_importer_pkg::*;
#(
    parameter int pBits       = pClockDomainBits,
    parameter int pSyncStages = pClockDomainSyncStages
) (
    input  logic             clk,
    input  logic             rst,
    input  iClockDomain_Exp  cd_e,
    output iClockDomain_Imp  cd_i,
    output logic             valid,
    output logic [pBits-1:0] data,
    input  logic             ready
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    if (pBits != pClockDomainBits) begin : g_width_check
        $error("clock_domain_importer: pBits must match the package word width");
    end

    logic [0:0]       r_state;
    logic             r_ack;
    logic [pBits-1:0] r_data;
    logic             w_req_s;
    logic             w_pending;
    logic             w_capture;
    logic             w_consume;

    clock_domain_sync #(
        .STAGES (pSyncStages)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (cd_e.req),
        .o_q (w_req_s)
    );

    assign w_pending = w_req_s ^ r_ack;
    // A full register only takes a new word when the current one leaves this edge,
    // so a stalled consumer withholds ack and backpressures the exporter.
    assign w_capture = w_pending && ((r_state == c_EMPTY) || ready);
    assign w_consume = (r_state == c_FULL) && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
            r_ack   <= 1'b0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_state <= c_FULL;
            r_ack   <= ~r_ack;
            r_data  <= cd_e.data;
        end else if (w_consume) begin
            r_state <= c_EMPTY;
        end
    end

    assign cd_i.ack = r_ack;
    assign valid    = (r_state == c_FULL);
    assign data     = r_data;

endmodule
`default_nettype wire
